// File: rtl/blue_exec_ctrl.sv
// Blue execution controller: owns a small register file and sequences one instruction at a
// time through the external combinational datapath (IDLE -> READ -> EXEC -> WB).
// Register indices are taken from the low REG_ADDR_W bits of ins[11:10] and ins[9:8], so
// REG_ADDR_W must be 1 or 2.
module blue_exec_ctrl #(
    parameter int unsigned REG_ADDR_W = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    input  logic [15:0]           ins,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_idx,
    input  logic [15:0]           ld_data,
    input  logic [REG_ADDR_W-1:0] rd_idx,
    output logic [15:0]           rd_data,
    output logic [15:0]           alu_ins,
    output logic [15:0]           alu_ra,
    output logic [15:0]           alu_rb,
    input  logic [15:0]           alu_ra_out,
    input  logic [15:0]           alu_rb_out,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      retired
);

    localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRead = 2'd1;
    localparam logic [1:0] StExec = 2'd2;
    localparam logic [1:0] StWb   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [15:0]           ir_q, ir_d;
    logic [15:0]           alu_ra_q, alu_ra_d;
    logic [15:0]           alu_rb_q, alu_rb_d;
    logic [15:0]           ra_res_q, ra_res_d;
    logic [15:0]           rb_res_q, rb_res_d;
    logic [CNT_W-1:0]      retired_q, retired_d;
    logic [15:0]           rf_q [NumRegs];
    logic [15:0]           rf_d [NumRegs];

    logic [REG_ADDR_W-1:0] ra_idx;
    logic [REG_ADDR_W-1:0] rb_idx;

    assign ra_idx = ir_q[10 +: REG_ADDR_W];
    assign rb_idx = ir_q[8 +: REG_ADDR_W];

    // Next-state for the sequencer, register file, operand and result registers.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_ra_d  = alu_ra_q;
        alu_rb_d  = alu_rb_q;
        ra_res_d  = ra_res_q;
        rb_res_d  = rb_res_q;
        retired_d = retired_q;
        rf_d      = rf_q;
        unique case (state_q)
            StIdle: begin
                // Host load wins over instruction accept; loads are only honoured here.
                if (ld_valid) begin
                    rf_d[ld_idx] = ld_data;
                end else if (ins_valid) begin
                    ir_d    = ins;
                    state_d = StRead;
                end
            end
            StRead: begin
                alu_ra_d = rf_q[ra_idx];
                alu_rb_d = rf_q[rb_idx];
                state_d  = StExec;
            end
            StExec: begin
                ra_res_d = alu_ra_out;
                rb_res_d = alu_rb_out;
                state_d  = StWb;
            end
            StWb: begin
                // On an index collision the RA result is the one that sticks.
                if (ra_idx != rb_idx) begin
                    rf_d[rb_idx] = rb_res_q;
                end
                rf_d[ra_idx] = ra_res_q;
                retired_d    = retired_q + CNT_W'(1);
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset; reset abandons any instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            alu_ra_q  <= '0;
            alu_rb_q  <= '0;
            ra_res_q  <= '0;
            rb_res_q  <= '0;
            retired_q <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alu_ra_q  <= alu_ra_d;
            alu_rb_q  <= alu_rb_d;
            ra_res_q  <= ra_res_d;
            rb_res_q  <= rb_res_d;
            retired_q <= retired_d;
            rf_q      <= rf_d;
        end
    end

    // Handshake, status and datapath-facing outputs.
    always_comb begin
        ins_ready = (state_q == StIdle) && !ld_valid;
        busy      = (state_q != StIdle);
        done      = (state_q == StWb);
        alu_ins   = ir_q;
        alu_ra    = alu_ra_q;
        alu_rb    = alu_rb_q;
        retired   = retired_q;
        rd_data   = rf_q[rd_idx];
    end

endmodule

// File: tb/tb_blue_exec_ctrl.sv
// Scoreboard bench for blue_exec_ctrl: a stimulus process predicts each instruction's effect
// on an abstract register-file model at accept time and queues it; a monitor process checks
// the DUT whenever done pulses.
module tb_blue_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins;
    logic        ld_valid;
    logic [1:0]  ld_idx;
    logic [15:0] ld_data;
    logic [1:0]  rd_idx;
    logic [15:0] rd_data;
    logic [15:0] alu_ins, alu_ra, alu_rb, alu_ra_out, alu_rb_out;
    logic        busy, done;
    logic [7:0]  retired;

    always #5 clk = ~clk;

    blue_exec_ctrl #(.REG_ADDR_W(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins        (ins),
        .ld_valid   (ld_valid),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .alu_ins    (alu_ins),
        .alu_ra     (alu_ra),
        .alu_rb     (alu_rb),
        .alu_ra_out (alu_ra_out),
        .alu_rb_out (alu_rb_out),
        .busy       (busy),
        .done       (done),
        .retired    (retired)
    );

    // Behavioural Blue datapath: returns {ra_out, rb_out}.
    function automatic logic [31:0] dp(input logic [15:0] ir, input logic [15:0] a,
                                       input logic [15:0] b);
        case (ir[15:13])
            3'd0:    dp = {a + b, b};
            3'd1:    dp = {a - b, b};
            3'd2:    dp = {a | b, b};
            3'd3:    dp = {a & b, b};
            3'd4:    dp = {a ^ b, b};
            3'd5:    dp = {a >> 1, b};
            3'd6:    dp = {b, b};
            default: dp = {b, a};
        endcase
    endfunction

    assign {alu_ra_out, alu_rb_out} = dp(alu_ins, alu_ra, alu_rb);

    typedef struct packed {
        logic [15:0]       ins;
        logic [15:0]       a;
        logic [15:0]       b;
        logic [3:0][15:0]  rf;
        logic [7:0]        ret;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_rf [4];
    int          m_ret;
    int          busy_cnt;
    int          n_chk;
    int          n_err;
    int          zero_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Apply an accepted instruction to the model and queue the predicted outcome.
    task automatic issue(input logic [15:0] iw);
        int          ra, rb;
        logic [15:0] a, b, ro, bo;
        exp_t        e;
        ra = int'(iw[11:10]);
        rb = int'(iw[9:8]);
        a  = m_rf[ra];
        b  = m_rf[rb];
        {ro, bo} = dp(iw, a, b);
        if (ra != rb) m_rf[rb] = bo;
        m_rf[ra] = ro;
        m_ret    = (m_ret + 1) % 256;
        e.ins    = iw;
        e.a      = a;
        e.b      = b;
        e.rf     = {m_rf[3], m_rf[2], m_rf[1], m_rf[0]};
        e.ret    = 8'(m_ret);
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus; checks handshake/status against the model's timeline.
    task automatic step(input logic r, input logic lv, input logic [1:0] li,
                        input logic [15:0] ld, input logic iv, input logic [15:0] iw);
        rst = r; ld_valid = lv; ld_idx = li; ld_data = ld; ins_valid = iv; ins = iw;
        @(negedge clk);
        chk("busy", 32'(busy), 32'(busy_cnt != 0));
        chk("done", 32'(done), 32'(busy_cnt == 1));
        chk("ins_ready", 32'(ins_ready), 32'(busy_cnt == 0 && !lv));
        if (r) begin
            for (int i = 0; i < 4; i++) m_rf[i] = '0;
            m_ret    = 0;
            busy_cnt = 0;
            exp_q.delete();
        end else if (busy_cnt != 0) begin
            busy_cnt--;
        end else if (lv) begin
            m_rf[li] = ld;
        end else if (iv) begin
            issue(iw);
            busy_cnt = 3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0);
    endtask

    // Monitor: register-file zero checks on request, and full outcome check on every done.
    initial begin : monitor
        int   zero_ack;
        exp_t e;
        zero_ack = 0;
        rd_idx   = 2'd0;
        forever begin
            @(negedge clk);
            if (zero_req != zero_ack) begin
                zero_ack = zero_req;
                for (int i = 0; i < 4; i++) begin
                    rd_idx = 2'(i);
                    #1;
                    chk("reset_rf", 32'(rd_data), 32'h0);
                end
                chk("reset_retired", 32'(retired), 32'h0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_without_issue", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("alu_ins", 32'(alu_ins), 32'(e.ins));
                    chk("alu_ra", 32'(alu_ra), 32'(e.a));
                    chk("alu_rb", 32'(alu_rb), 32'(e.b));
                    @(negedge clk);
                    chk("retired", 32'(retired), 32'(e.ret));
                    for (int i = 0; i < 4; i++) begin
                        rd_idx = 2'(i);
                        #1;
                        chk("rf_after_wb", 32'(rd_data), 32'(e.rf[i]));
                    end
                end
            end
        end
    end

    initial begin : stim
        n_chk = 0; n_err = 0; zero_req = 0; m_ret = 0; busy_cnt = 0;
        for (int i = 0; i < 4; i++) m_rf[i] = '0;
        rst = 1'b1; ld_valid = 1'b0; ld_idx = '0; ld_data = '0; ins_valid = 1'b0; ins = '0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0);
        zero_req++;
        idle(3);

        // Basic ADD r0,r1.
        step(1'b0, 1'b1, 2'd0, 16'h0005, 1'b0, 16'h0);
        step(1'b0, 1'b1, 2'd1, 16'h0003, 1'b0, 16'h0);
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 16'h0100);
        idle(4);

        // EXCH r2,r3, then same-index EXCH r1,r1.
        step(1'b0, 1'b1, 2'd2, 16'h1234, 1'b0, 16'h0);
        step(1'b0, 1'b1, 2'd3, 16'hABCD, 1'b0, 16'h0);
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 16'hEB00);
        idle(4);
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 16'hE500);
        idle(4);

        // Load and instruction offered together: load wins until ld_valid drops.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd2, 16'h5555 + 16'(i), 1'b1, 16'h4100);
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 16'h4100);
        // Loads while busy must be dropped.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'(i), 16'hDEAD, 1'b0, 16'h0);
        idle(2);

        // Reset during EXEC of SUB r0,r1.
        step(1'b0, 1'b1, 2'd0, 16'h0009, 1'b0, 16'h0);
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 16'h2100);
        step(1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 16'h0);
        zero_req++;
        idle(3);

        // 256 back-to-back MOVs with ins_valid held high; retired wraps.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), 16'($urandom), 1'b0, 16'h0);
        for (int n = 0; n < 256; n++) begin
            logic [15:0] mv;
            mv = 16'hC000 | (16'($urandom_range(0, 3)) << 10) | (16'($urandom_range(0, 3)) << 8);
            for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 2'd0, 16'h0, 1'b1, mv);
        end

        // Randomized mix of loads, instructions and idle cycles.
        for (int n = 0; n < 600; n++) begin
            step(1'b0, ($urandom % 4) == 0, 2'($urandom), 16'($urandom),
                 ($urandom % 2) == 0, 16'($urandom));
        end

        idle(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
